// File: rtl/mem_bus_stage_if.sv
// Data-bus bundle between the MEM pipeline stage (master) and the memory slave.
// The master issues a word-addressed request with big-endian byte enables and
// holds it until the slave returns a one-cycle ack with read data.
interface mem_bus_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output sel,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  sel,
        input  wdata,
        output ack,
        output rdata
    );
endinterface

// File: rtl/mem_bus_stage.sv
// MEM pipeline stage. Non-memory operations pass straight from EX/MEM to
// MEM/WB. Aligned loads/stores run one bus transaction through a three-state
// FSM (IDLE -> BUSY -> optional HOLD), stalling the pipeline while waiting.
// Misaligned accesses never reach the bus and have their register write
// suppressed. A BUSY phase without ack is aborted after BUS_TIMEOUT cycles.
module mem_bus_stage #(
    parameter int unsigned BUS_TIMEOUT = 32'd255,
    parameter int unsigned TO_W        = 32'd8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic [4:0]             wd_i,
    input  logic                   wreg_i,
    input  logic [31:0]            wdata_i,
    input  logic [31:0]            hi_i,
    input  logic [31:0]            lo_i,
    input  logic                   whilo_i,
    input  logic [7:0]             aluop_i,
    input  logic [31:0]            mem_addr_i,
    input  logic [31:0]            reg2_i,
    output logic [4:0]             wd_o,
    output logic                   wreg_o,
    output logic [31:0]            wdata_o,
    output logic [31:0]            hi_o,
    output logic [31:0]            lo_o,
    output logic                   whilo_o,
    mem_bus_stage_if.master        bus,
    output logic                   stallreq_o,
    output logic                   bus_err_o
);
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              tmo_flag_q, tmo_flag_d;

    logic              is_load_s;
    logic              is_store_s;
    logic              is_mem_s;
    logic              misalign_s;
    logic              tmo_hit_s;
    logic              unused_stall_s;

    // Big-endian byte enables: lane 3 carries address offset 00.
    function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] a);
        logic [3:0] s;
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: s = 4'b1000 >> a;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: s = a[1] ? 4'b0011 : 4'b1100;
            default:                          s = 4'b1111;
        endcase
        return s;
    endfunction

    // Stores replicate the datum across every lane so the slave can take any.
    function automatic logic [31:0] store_lanes(input logic [7:0] op, input logic [31:0] d);
        logic [31:0] r;
        case (op)
            EXE_SB_OP: r = {4{d[7:0]}};
            EXE_SH_OP: r = {2{d[15:0]}};
            EXE_SW_OP: r = d;
            default:   r = 32'd0;
        endcase
        return r;
    endfunction

    // Pick the addressed byte/half from a bus word and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [7:0] op, input logic [1:0] a,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = rd[31:24];
            2'b01:   b = rd[23:16];
            2'b10:   b = rd[15:8];
            default: b = rd[7:0];
        endcase
        h = a[1] ? rd[15:0] : rd[31:16];
        case (op)
            EXE_LB_OP:  r = {{24{b[7]}}, b};
            EXE_LBU_OP: r = {24'd0, b};
            EXE_LH_OP:  r = {{16{h[15]}}, h};
            EXE_LHU_OP: r = {16'd0, h};
            default:    r = rd;
        endcase
        return r;
    endfunction

    // Classify the EX/MEM operation into load/store and flag misalignment.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        misalign_s = 1'b0;
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP: is_load_s = 1'b1;
            EXE_LH_OP, EXE_LHU_OP: begin
                is_load_s  = 1'b1;
                misalign_s = mem_addr_i[0];
            end
            EXE_LW_OP: begin
                is_load_s  = 1'b1;
                misalign_s = (mem_addr_i[1:0] != 2'b00);
            end
            EXE_SB_OP: is_store_s = 1'b1;
            EXE_SH_OP: begin
                is_store_s = 1'b1;
                misalign_s = mem_addr_i[0];
            end
            EXE_SW_OP: begin
                is_store_s = 1'b1;
                misalign_s = (mem_addr_i[1:0] != 2'b00);
            end
            default: is_load_s = 1'b0;
        endcase
    end

    assign is_mem_s  = is_load_s | is_store_s;
    // A zero BUS_TIMEOUT disables the abort entirely.
    assign tmo_hit_s = (BUS_TIMEOUT != 32'd0) && (cnt_q == TO_W'(BUS_TIMEOUT - 32'd1));

    // FSM next state, bus register next values and the combinational MEM/WB outputs.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        tmo_flag_d = tmo_flag_q;
        stallreq_o = 1'b0;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        case (state_q)
            ST_IDLE: begin
                if (is_mem_s && misalign_s) begin
                    wreg_o = 1'b0;
                end else if (is_mem_s) begin
                    stallreq_o = 1'b1;
                    req_d      = 1'b1;
                    we_d       = is_store_s;
                    addr_d     = {mem_addr_i[31:2], 2'b00};
                    sel_d      = lane_sel(aluop_i, mem_addr_i[1:0]);
                    wdata_d    = store_lanes(aluop_i, reg2_i);
                    cnt_d      = '0;
                    tmo_flag_d = 1'b0;
                    state_d    = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.ack) begin
                    wdata_o = load_extend(aluop_i, mem_addr_i[1:0], bus.rdata);
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    rbuf_d  = bus.rdata;
                    cnt_d   = '0;
                    state_d = stall[3] ? ST_HOLD : ST_IDLE;
                end else if (tmo_hit_s) begin
                    wreg_o     = 1'b0;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    err_d      = 1'b1;
                    tmo_flag_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = stall[3] ? ST_HOLD : ST_IDLE;
                end else begin
                    stallreq_o = 1'b1;
                    cnt_d      = cnt_q + TO_W'(1);
                end
            end
            ST_HOLD: begin
                // EX/MEM is frozen while MEM is held, so aluop/addr still describe this access.
                wdata_o = load_extend(aluop_i, mem_addr_i[1:0], rbuf_q);
                wreg_o  = wreg_i & ~tmo_flag_q;
                if (stall[3]) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and bus-side registers; async reset drops any request immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            sel_q      <= 4'd0;
            wdata_q    <= 32'd0;
            rbuf_q     <= 32'd0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.sel   = sel_q;
    assign bus.wdata = wdata_q;
    assign bus_err_o = err_q;

    assign wd_o    = wd_i;
    assign hi_o    = hi_i;
    assign lo_o    = lo_i;
    assign whilo_o = whilo_i;

    // Only the MEM-held bit of the stall vector matters here.
    assign unused_stall_s = ^{stall[5:4], stall[2:0]};
endmodule
